ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte from the FPGA to the keyboard, e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable.
- It is the transmit side of the PS/2 link. The existing PS2_Controller receiver handles device-to-host traffic.
- It drives PS2_CLK/PS2_DAT as open-drain, through output enables resolved at top level. Software or the game FSM pulses tx_start with a byte, and the block reports done or error.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles PS2 clock is held low before request-to-send (120 us at 50 MHz).
- START_TIMEOUT, 750000: max cycles from clock release to the first device falling edge (15 ms).
- PACKET_TIMEOUT, 100000: max cycles from the first falling edge to the ack edge (2 ms).
- TIMER_W, 20: width of the shared down/up timer; must hold the largest of the three cycle parameters.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte; sampled on the accept cycle.
- tx_start  in  1  request to send; accepted only in IDLE.
- tx_busy  out  1  high whenever state != IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and device acknowledged.
- tx_error  out  1  one-cycle pulse: timeout or missing ack.
- ps2_clk_in  in  1  raw PS2_CLK pin value.
- ps2_dat_in  in  1  raw PS2_DAT pin value.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release (Z).
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release (Z).

Behaviour:
- Reset, asynchronous: state = IDLE. tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe all = 0. Synchronizers preset to 1.
- Reset asserted mid-packet: both lines are released immediately (same delta, not the next edge), with no done or error pulse.
- Inputs pass through a 2-flop synchronizer. fall = sync_clk_prev & ~sync_clk, one cycle wide. Latency from pin to fall is 3 clk.
- States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
- IDLE:
  - On tx_start=1: latch tx_data into shreg[7:0] and set shreg[8] = ~^tx_data (odd parity).
  - Load the timer with 0, clear bitcnt, go to INHIBIT.
  - tx_start in any other state is ignored and no byte is queued.
- INHIBIT:
  - clk_oe = 1.
  - dat_oe = 0 until the timer reaches INHIBIT_CYCLES-1, then dat_oe = 1 for that last cycle (start bit).
  - After INHIBIT_CYCLES cycles go to RTS and clear the timer.
- RTS:
  - clk_oe = 0, dat_oe = 1.
  - On fall: drive bit0 (dat_oe = ~shreg[0]), bitcnt = 1, clear the timer, go to SHIFT.
  - If the timer reaches START_TIMEOUT first: error.
- SHIFT:
  - On each fall, update dat_oe:
    - bitcnt 1..7: dat_oe = ~data[bitcnt].
    - bitcnt 8: dat_oe = ~parity.
    - bitcnt 9: dat_oe = 0 (stop bit, line released).
  - Increment bitcnt on each fall. After the fall with bitcnt = 9, go to ACK.
- ACK:
  - On the next fall (11th overall), sample sync_dat.
  - 0: go to WAIT_IDLE. 1: error.
- WAIT_IDLE:
  - Wait until sync_clk = 1 and sync_dat = 1 on the same cycle.
  - Then pulse tx_done and go to IDLE.
- Packet timeout: the timer runs through SHIFT, ACK and WAIT_IDLE. Reaching PACKET_TIMEOUT = error.
- Error: release both lines, pulse tx_error for 1 cycle, go to IDLE. tx_done and tx_error are never both high.
- Data and parity change only on device falling edges. The host never toggles dat_oe while sync_clk is high in SHIFT.
- tx_busy drops in the same cycle that tx_done or tx_error pulses. A new tx_start is accepted on the following cycle.
- Timer saturates; it never wraps.

Test Plan:
- Send 0xED with a bench device model (10 us clock, acks):
  - Bits on the DAT line after the start 0: 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Device ack 0, then tx_done pulses once and tx_busy falls in the same cycle.
- Send 0xF4 and then 0x00 back to back:
  - Parity is 0 for 0xF4 and 1 for 0x00.
  - clk_oe is held for exactly INHIBIT_CYCLES cycles, with dat_oe=1 only in its last cycle.
  - The second tx_start is accepted one cycle after the first done.
- Device never clocks (INHIBIT_CYCLES=10, START_TIMEOUT=50): tx_error pulses 50 cycles after RTS entry, both oe = 0, no tx_done.
- Device leaves DAT high on the 11th falling edge: tx_error pulses, and lines are released.
- Device stops clocking after bit 4 (PACKET_TIMEOUT=200): tx_error at the 200th cycle after the first fall.
- Assert reset during SHIFT after bit 3: clk_oe and dat_oe go to 0 asynchronously, state = IDLE, no pulses.
- Pulse tx_start=1 with 0x55 while busy: ignored, and the original byte completes unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one
// command byte (odd parity) on device clock edges and checks the device ack.
`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int PACKET_TIMEOUT = 100000,
    parameter int TIMER_W        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [TIMER_W-1:0] INH_LAST    = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] INH_PRE     = TIMER_W'(INHIBIT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] START_LAST  = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] PACKET_LAST = TIMER_W'(PACKET_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         bitcnt_q, bitcnt_d;
    logic [8:0]         shreg_q, shreg_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               clk_meta_q, clk_sync_q, clk_prev_q;
    logic               dat_meta_q, dat_sync_q;
    logic               fall;
    logic               fail;

    assign fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        fail     = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                if (tx_start) begin
                    shreg_d  = {~^tx_data, tx_data};
                    timer_d  = '0;
                    bitcnt_d = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    timer_d  = '0;
                    state_d  = RTS;
                end else if (timer_q == INH_PRE) begin
                    // Start bit goes out in the final inhibit cycle.
                    dat_oe_d = 1'b1;
                end
            end
            RTS: begin
                if (fall) begin
                    dat_oe_d = ~shreg_q[0];
                    bitcnt_d = 4'd1;
                    timer_d  = '0;
                    state_d  = SHIFT;
                end else if (timer_q >= START_LAST) begin
                    fail = 1'b1;
                end
            end
            SHIFT: begin
                if (timer_q >= PACKET_LAST) begin
                    fail = 1'b1;
                end else if (fall) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end else begin
                        dat_oe_d = ~shreg_q[bitcnt_q];
                    end
                end
            end
            ACK: begin
                if (timer_q >= PACKET_LAST) begin
                    fail = 1'b1;
                end else if (fall) begin
                    if (dat_sync_q) fail = 1'b1;
                    else            state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (timer_q >= PACKET_LAST) begin
                    fail = 1'b1;
                end else if (clk_sync_q && dat_sync_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            error_d  = 1'b1;
            state_d  = IDLE;
        end
    end

    // NOTE: the async reset clears the output enables directly, so a reset
    // mid-packet releases both lines without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a default-parameter instance for normal
// transfers and a short-timeout instance for the error paths, on one bus.
`timescale 1ns/1ps

module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       a_start, b_start;
    logic       a_busy, a_done, a_err, a_clk_oe, a_dat_oe;
    logic       b_busy, b_done, b_err, b_clk_oe, b_dat_oe;
    logic       dev_clk_low, dev_dat_low;
    logic       sel;
    wire        ps2_clk = ~(a_clk_oe | b_clk_oe | dev_clk_low);
    wire        ps2_dat = ~(a_dat_oe | b_dat_oe | dev_dat_low);
    wire        cur_busy   = sel ? b_busy   : a_busy;
    wire        cur_done   = sel ? b_done   : a_done;
    wire        cur_err    = sel ? b_err    : a_err;
    wire        cur_clk_oe = sel ? b_clk_oe : a_clk_oe;
    wire        cur_dat_oe = sel ? b_dat_oe : a_dat_oe;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int bad_pulse = 0;
    int err_cyc = 0;
    logic prev_busy = 1'b0;

    ps2_host_tx dut_a (
        .clk(clk), .reset(rst), .tx_data(tx_data), .tx_start(a_start),
        .tx_busy(a_busy), .tx_done(a_done), .tx_error(a_err),
        .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat),
        .ps2_clk_oe(a_clk_oe), .ps2_dat_oe(a_dat_oe)
    );

    ps2_host_tx #(.INHIBIT_CYCLES(10), .START_TIMEOUT(50), .PACKET_TIMEOUT(200)) dut_b (
        .clk(clk), .reset(rst), .tx_data(tx_data), .tx_start(b_start),
        .tx_busy(b_busy), .tx_done(b_done), .tx_error(b_err),
        .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat),
        .ps2_clk_oe(b_clk_oe), .ps2_dat_oe(b_dat_oe)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse bookkeeping: a pulse must coincide with busy falling, never both.
    always @(negedge clk) begin
        if (cur_done || cur_err) begin
            if (cur_busy || !prev_busy || (cur_done && cur_err)) bad_pulse++;
        end
        if (cur_done) done_cnt++;
        if (cur_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        prev_busy = cur_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] d, output int s);
        tx_data = d;
        if (sel) b_start = 1'b1;
        else     a_start = 1'b1;
        step();
        a_start = 1'b0;
        b_start = 1'b0;
        s = cyc;
        check("busy_after_start", 32'(cur_busy), 32'd1);
    endtask

    task automatic check_inhibit(input int n);
        int   hold;
        int   dat_hi;
        logic last;
        hold   = 0;
        dat_hi = 0;
        last   = 1'b0;
        while (cur_clk_oe === 1'b1 && hold < n + 10) begin
            hold++;
            if (cur_dat_oe) dat_hi++;
            last = cur_dat_oe;
            step();
        end
        check("inhibit_len", 32'(hold), 32'(n));
        check("inhibit_dat_cycles", 32'(dat_hi), 32'd1);
        check("inhibit_dat_last", 32'(last), 32'd1);
        check("rts_oe", 32'({cur_clk_oe, cur_dat_oe}), 32'b01);
    endtask

    // Device model: clocks n_falls bits, samples DAT late in each low phase,
    // and drives the ack low before the 11th falling edge when ack is set.
    task automatic dev_clock(input int half, input int n_falls, input bit ack,
                             output logic [9:0] bits, output logic start_bit,
                             output int first_cyc);
        bits      = '0;
        first_cyc = 0;
        repeat (20) step();
        start_bit = ps2_dat;
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 1) first_cyc = cyc;
            dev_clk_low = 1'b1;
            repeat (half) step();
            if (k <= 10) bits[k-1] = ps2_dat;
            dev_clk_low = 1'b0;
            repeat (half / 2) step();
            if (k == 10) dev_dat_low = ack;
            repeat (half - half / 2) step();
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_pulse(input int d0, input int e0, input int bound);
        int n;
        n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < bound) begin
            step();
            n++;
        end
        check("pulse_seen", 32'(n < bound), 32'd1);
    endtask

    initial begin
        logic [9:0] bits;
        logic       sb;
        int         fc, s, d0, e0;

        rst = 1'b1; tx_data = '0; a_start = 1'b0; b_start = 1'b0;
        dev_clk_low = 1'b0; dev_dat_low = 1'b0; sel = 1'b0;
        #1;
        check("reset_outputs", 32'({a_busy, a_done, a_err, a_clk_oe, a_dat_oe}), 32'd0);
        check("reset_lines", 32'({ps2_clk, ps2_dat}), 32'b11);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        step(); step();

        // 0xED: data 1,0,1,1,0,1,1,1, parity 1, stop 1
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED, s);
        check_inhibit(6000);
        dev_clock(250, 11, 1'b1, bits, sb, fc);
        check("ed_start_bit", 32'(sb), 32'd0);
        check("ed_bits", 32'(bits), 32'h3ED);
        wait_pulse(d0, e0, 50);
        check("ed_done_busy", 32'({cur_done, cur_busy}), 32'b10);
        repeat (5) step();
        check("ed_done_once", 32'(done_cnt - d0), 32'd1);
        check("ed_no_error", 32'(err_cnt - e0), 32'd0);

        // 0xF4 then 0x00 back to back
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4, s);
        check_inhibit(6000);
        dev_clock(250, 11, 1'b1, bits, sb, fc);
        check("f4_bits", 32'(bits), 32'h2F4);
        wait_pulse(d0, e0, 50);
        check("f4_done", 32'(done_cnt - d0), 32'd1);
        start_tx(8'h00, s);
        check_inhibit(6000);
        dev_clock(250, 11, 1'b1, bits, sb, fc);
        check("z_bits", 32'(bits), 32'h300);
        wait_pulse(d0 + 1, e0, 50);
        repeat (5) step();
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_no_error", 32'(err_cnt - e0), 32'd0);

        // Reset during SHIFT after bit 3 (bit 3 of 0xF4 is 0, so DAT is held)
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4, s);
        check_inhibit(6000);
        dev_clock(250, 4, 1'b1, bits, sb, fc);
        check("pre_reset_dat_oe", 32'(cur_dat_oe), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_reset_release", 32'({a_clk_oe, a_dat_oe, a_busy}), 32'd0);
        check("async_reset_line", 32'(ps2_dat), 32'd1);
        step();
        rst = 1'b0;
        repeat (5) step();
        check("reset_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // 0xA5 with a 0x55 start pulse while busy
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hA5, s);
        check_inhibit(6000);
        tx_data = 8'h55;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        dev_clock(250, 11, 1'b1, bits, sb, fc);
        check("a5_bits", 32'(bits), 32'h3A5);
        wait_pulse(d0, e0, 50);
        repeat (20) step();
        check("busy_start_ignored", 32'(cur_busy), 32'd0);
        check("a5_done_once", 32'(done_cnt - d0), 32'd1);

        // Short-timeout instance: device never clocks
        sel = 1'b1;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4, s);
        check_inhibit(10);
        wait_pulse(d0, e0, 100);
        check("rts_timeout_cycle", 32'(err_cyc - s), 32'd60);
        check("rts_timeout_err", 32'(err_cnt - e0), 32'd1);
        check("rts_timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("rts_timeout_oe", 32'({cur_clk_oe, cur_dat_oe, cur_busy}), 32'd0);

        // Device leaves DAT high on the 11th falling edge
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED, s);
        check_inhibit(10);
        dev_clock(6, 11, 1'b0, bits, sb, fc);
        wait_pulse(d0, e0, 50);
        check("nack_bits", 32'(bits), 32'h3ED);
        check("nack_err", 32'(err_cnt - e0), 32'd1);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        check("nack_lines", 32'({cur_clk_oe, cur_dat_oe, ps2_clk, ps2_dat}), 32'b0011);

        // Device stops after bit 4; host fall is 3 cycles after the pin fall
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4, s);
        check_inhibit(10);
        dev_clock(6, 5, 1'b1, bits, sb, fc);
        wait_pulse(d0, e0, 300);
        check("pkt_timeout_cycle", 32'(err_cyc - fc), 32'd203);
        check("pkt_timeout_no_done", 32'(done_cnt - d0), 32'd0);
        check("pkt_timeout_oe", 32'({cur_clk_oe, cur_dat_oe, cur_busy}), 32'd0);

        check("pulse_rules", 32'(bad_pulse), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
